// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the run-time clock divider controller.
package clkdiv_pkg;

  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned CMD_STOP    = 0;
  localparam int unsigned CMD_ILLEGAL = 1;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    RUN    = 2'd1,
    SWITCH = 2'd2
  } state_e;

endpackage

// File: rtl/clkdiv_core.sv
// Period counter with posedge/negedge phase flops; ORed into a 50%-duty clock.
module clkdiv_core
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] div_r,
  input  logic             odd_r,
  input  logic             run,
  input  logic             load,
  output logic [CNT_W-1:0] cnt,
  output logic             out_clk,
  output logic             period_tick
);

  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] last;
  logic [CNT_W-1:0] half;
  logic             p_q;
  logic             n_q;

  // Wrap by compare against the active ratio; a load restarts the period.
  always_comb begin
    last     = div_r - CNT_W'(1);
    half     = div_r >> 1;
    cnt_next = '0;
    if (run && !load && (cnt != last)) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      p_q         <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      p_q         <= load | (run && (cnt_next < half));
      period_tick <= run && !load && (cnt_next == last);
    end
  end

  // Half-cycle extension of the high phase for odd ratios.
  always_ff @(negedge clk) begin
    if (!rst) begin
      n_q <= 1'b0;
    end else begin
      n_q <= p_q & odd_r;
    end
  end

  assign out_clk = p_q | n_q;

endmodule

// File: rtl/clkdiv_sched.sv
// Command handshake and FSM deferring ratio changes/stops to period boundaries.
module clkdiv_sched
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             out_clk,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div,
  output logic             period_tick
);

  state_e           state;
  state_e           state_next;
  logic [CNT_W-1:0] div_r;
  logic             odd_r;
  logic [CNT_W-1:0] pend;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             illegal;
  logic             boundary;
  logic             apply;
  logic             store;
  logic             load;
  logic             stop;
  logic             run;
  logic [CNT_W-1:0] apply_div;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= OFF;
    end else begin
      state <= state_next;
    end
  end

  // Decide whether a command applies now, is parked in pend, or is ignored.
  always_comb begin
    accept    = cfg_valid && cfg_ready;
    illegal   = (cfg_div == CNT_W'(CMD_ILLEGAL));
    boundary  = (state != OFF) && (cnt == div_r - CNT_W'(1));
    apply     = 1'b0;
    store     = 1'b0;
    apply_div = cfg_div;
    case (state)
      OFF:     apply = accept && !illegal && (cfg_div != CNT_W'(CMD_STOP));
      RUN: begin
        if (accept && !illegal) begin
          apply = boundary;
          store = !boundary;
        end
      end
      SWITCH: begin
        apply     = boundary;
        apply_div = pend;
      end
      default: apply = 1'b0;
    endcase
    load = apply && (apply_div != CNT_W'(CMD_STOP));
    stop = apply && (apply_div == CNT_W'(CMD_STOP));
  end

  always_comb begin
    state_next = state;
    case (state)
      OFF:     if (load) state_next = RUN;
      RUN: begin
        if (stop)       state_next = OFF;
        else if (store) state_next = SWITCH;
      end
      SWITCH: begin
        if (stop)      state_next = OFF;
        else if (load) state_next = RUN;
      end
      default: state_next = OFF;
    endcase
    run = (state_next != OFF);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_r     <= '0;
      odd_r     <= 1'b0;
      pend      <= '0;
      cfg_err   <= 1'b0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      if (load) begin
        div_r <= apply_div;
        odd_r <= apply_div[0];
      end else if (stop) begin
        div_r <= '0;
        odd_r <= 1'b0;
      end
      if (store) begin
        pend <= cfg_div;
      end
      cfg_err   <= accept && illegal;
      cfg_ready <= (state_next != SWITCH);
      busy      <= (state_next != OFF);
    end
  end

  assign cur_div = div_r;

  clkdiv_core #(.CNT_W(CNT_W)) u_core (
    .clk         (clk),
    .rst         (rst),
    .div_r       (div_r),
    .odd_r       (odd_r),
    .run         (run),
    .load        (load),
    .cnt         (cnt),
    .out_clk     (out_clk),
    .period_tick (period_tick)
  );

endmodule

// File: tb/tb_clkdiv_sched.sv
// Self-checking bench for clkdiv_sched: period-position model plus directed literal checks.
module tb_clkdiv_sched;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic             cfg_ready;
  logic             cfg_err;
  logic             out_clk;
  logic             busy;
  logic [CNT_W-1:0] cur_div;
  logic             period_tick;

  int tests = 0;
  int fails = 0;

  // Model: whether running, ratio, position within the period, pending command.
  bit m_live = 0;
  bit m_just_rst = 0;
  bit m_run = 0;
  bit m_sw = 0;
  bit m_err = 0;
  bit m_ready = 1;
  int m_n = 0;
  int m_pos = 0;
  int m_pend = 0;

  clkdiv_sched #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_div     (cfg_div),
    .cfg_ready   (cfg_ready),
    .cfg_err     (cfg_err),
    .out_clk     (out_clk),
    .busy        (busy),
    .cur_div     (cur_div),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic model_apply(input int d);
    if (d == 0) begin
      m_run = 0;
      m_n   = 0;
      m_pos = 0;
    end else begin
      m_run = 1;
      m_n   = d;
      m_pos = 0;
    end
  endtask

  task automatic model_step();
    bit acc;
    bit bnd;
    int d;
    if (!rst) begin
      m_run = 0; m_sw = 0; m_err = 0; m_n = 0; m_pos = 0; m_pend = 0;
      m_live = 1; m_just_rst = 1;
    end else begin
      acc = cfg_valid && m_ready;
      d   = int'(cfg_div);
      bnd = m_run && (m_pos == m_n - 1);
      m_err = acc && (d == 1);
      m_just_rst = 0;
      if (m_sw) begin
        if (bnd) begin
          m_sw = 0;
          model_apply(m_pend);
        end else begin
          m_pos++;
        end
      end else if (acc && d != 1) begin
        if (!m_run) begin
          if (d != 0) model_apply(d);
        end else if (bnd) begin
          model_apply(d);
        end else begin
          m_sw = 1;
          m_pend = d;
          m_pos++;
        end
      end else if (m_run) begin
        m_pos = bnd ? 0 : m_pos + 1;
      end
    end
    m_ready = !m_sw;
  endtask

  // Compare process: out_clk is high for the first ceil(N/2) half-slots of the
  // first half of each cycle and floor(N/2) for the second half.
  always begin
    @(posedge clk);
    model_step();
    #1;
    if (m_live) begin
      chk("busy", 32'(busy), 32'(m_run));
      chk("cur_div", 32'(cur_div), m_run ? m_n : 0);
      chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
      chk("period_tick", 32'(period_tick), 32'(m_run && (m_pos == m_n - 1)));
      if (!m_just_rst)
        chk("out_clk_h1", 32'(out_clk), 32'(m_run && (m_pos < (m_n + 1) / 2)));
    end
    @(negedge clk);
    #1;
    if (m_live)
      chk("out_clk_h2", 32'(out_clk), 32'(m_run && (m_pos < m_n / 2)));
  end

  task automatic issue(input int d);
    bit acc;
    int g;
    g = 0;
    cfg_valid = 1'b1;
    cfg_div   = CNT_W'(d);
    acc = 0;
    while (!acc && g < 300) begin
      acc = cfg_ready;
      @(posedge clk);
      g++;
    end
    if (!acc) fail_now("issue");
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    int g;
    g = 0;
    @(negedge clk);
    while (m_pos != p && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (m_pos != p) fail_now("wait_pos");
  endtask

  // Length of one full high and low phase, in half clk cycles.
  task automatic measure(output int hi, output int lo);
    int g;
    hi = 0; lo = 0; g = 0;
    #1;
    while (out_clk !== 1'b0 && g < 400) begin @(clk); #1; g++; end
    while (out_clk !== 1'b1 && g < 400) begin @(clk); #1; g++; end
    while (out_clk === 1'b1 && g < 400) begin hi++; @(clk); #1; g++; end
    while (out_clk === 1'b0 && g < 400) begin lo++; @(clk); #1; g++; end
    if (g >= 400) fail_now("measure");
  endtask

  initial begin
    int hi;
    int lo;
    int rl;
    int g;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_out_clk", 32'(out_clk), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    chk("rst_cur_div", 32'(cur_div), 0);

    issue(4);
    chk("n4_cur_div", 32'(cur_div), 4);
    measure(hi, lo);
    chk("n4_hi", hi, 4);
    chk("n4_lo", lo, 4);

    // Mid-period ratio change parks the command until the boundary.
    wait_pos(1);
    issue(6);
    rl = 0; g = 0;
    while (g < 20) begin
      #1;
      if (cfg_ready === 1'b0) rl++;
      else break;
      @(negedge clk);
      g++;
    end
    chk("sw_ready_low", rl, 2);
    measure(hi, lo);
    chk("n6_hi", hi, 6);
    chk("n6_lo", lo, 6);
    chk("n6_cur_div", 32'(cur_div), 6);

    // Command landing on the boundary applies the same edge.
    wait_pos(5);
    issue(3);
    chk("bnd_cur_div", 32'(cur_div), 3);
    for (int i = 0; i < 3; i++) begin
      chk("bnd_ready", 32'(cfg_ready), 1);
      @(negedge clk);
    end
    measure(hi, lo);
    chk("n3_hi", hi, 3);
    chk("n3_lo", lo, 3);

    issue(5);
    measure(hi, lo);
    chk("n5_hi", hi, 5);
    chk("n5_lo", lo, 5);

    issue(1);
    chk("ill_err", 32'(cfg_err), 1);
    chk("ill_cur_div", 32'(cur_div), 5);
    @(negedge clk);
    chk("ill_err_drop", 32'(cfg_err), 0);

    issue(0);
    g = 0;
    while (busy !== 1'b0 && g < 20) begin @(negedge clk); g++; end
    chk("stop_busy", 32'(busy), 0);
    chk("stop_cur_div", 32'(cur_div), 0);
    chk("stop_out_clk", 32'(out_clk), 0);

    issue(1);
    chk("off_ill_err", 32'(cfg_err), 1);
    issue(0);
    chk("off_stop_busy", 32'(busy), 0);

    // Reset in the middle of an N=7 high phase.
    issue(7);
    wait_pos(1);
    chk("n7_high", 32'(out_clk), 1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("mid_rst_out_clk", 32'(out_clk), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_cur_div", 32'(cur_div), 0);
    chk("mid_rst_ready", 32'(cfg_ready), 1);
    chk("mid_rst_tick", 32'(period_tick), 0);
    @(negedge clk);
    rst = 1'b1;

    issue(2);
    measure(hi, lo);
    chk("n2_hi", hi, 2);
    chk("n2_lo", lo, 2);

    wait_pos(1);
    issue(0);
    chk("bnd_stop_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clkdiv_sched.md
# clkdiv_sched

Run-time controller for the 50%-duty integer clock divider. It accepts divide-ratio and stop commands over a valid/ready port, and runs a counter with posedge and negedge phase flops that produces `out_clk`. Ratio changes and stops take effect only at a period boundary, so `out_clk` never glitches or produces a runt pulse. It sits between the configuration logic and the divided-clock consumers.

## Interface
- `CNT_W`, default 8: width of the divide ratio and the period counter; legal ratio is 2..2^CNT_W-1.
- `clk`  in  1  source clock.
- `rst`  in  1  reset, synchronous, active-low; clock `clk`.
- `cfg_valid`  in  1  command valid.
- `cfg_div`  in  CNT_W  command payload:
  - 0 = stop.
  - 1 = illegal.
  - 2 or more = divide ratio N.
- `cfg_ready`  out  1  command can be accepted this cycle.
- `cfg_err`  out  1  one-cycle pulse after an illegal command is accepted.
- `out_clk`  out  1  divided clock, 50% duty for both even and odd N.
- `busy`  out  1  state is not OFF.
- `cur_div`  out  CNT_W  active ratio; 0 in OFF.
- `period_tick`  out  1  high during the last clk cycle of each out_clk period.

## Operation
- Handshake:
  - A command is accepted on a posedge where `cfg_valid && cfg_ready`.
  - `cfg_ready = (state != SWITCH)`.
  - `cfg_div`/`cfg_valid` must be held stable until accepted.
- States:
  - **OFF**:
    - Accepting ratio N: `div_r<=N`, `cnt<=0`, `p_q<=1`, go to RUN.
    - Accepting stop: no effect.
  - **RUN**: `cnt` counts 0..div_r-1 and wraps to 0. Accepting a command:
    - If `cnt == div_r-1` at the accepting edge, the command applies immediately:
      - ratio: reload `div_r`, `cnt<=0`, stay in RUN.
      - stop: go to OFF.
    - Otherwise it is stored in `pend`, go to SWITCH.
  - **SWITCH**: counting continues with the old `div_r`. At the edge where `cnt == div_r-1`, `pend` is applied exactly as above.
- Illegal command (`cfg_div==1`):
  - Accepted, `cfg_err` pulses for one cycle, state and outputs are unchanged.
  - This rule applies in every state.
- Phase generation:
  - H = N/2 for even N, (N-1)/2 for odd N.
  - `p_q` is posedge-registered: `p_q <= (cnt_next < H)` while running, 0 in OFF.
  - `n_q` is negedge-registered: `n_q <= p_q & odd_r`.
  - `out_clk = p_q | n_q`.
  - For odd N, the high time is H+0.5 clk cycles.
- Width rules:
  - `cnt` and `div_r` are CNT_W bits. `cnt` never exceeds `div_r-1`.
  - `cnt_next` wraps by compare, not by overflow.
- Reset (`rst==0`):
  - At posedge: state=OFF, `cnt=0`, `div_r=0`, `p_q=0`, `pend=0`, `cfg_err=0`, `period_tick=0`.
  - At negedge: `n_q=0`.
  - `cfg_ready` is 1 after reset.
  - Reset mid-period forces `out_clk` low within half a clk cycle, with no further edges.

## Timing
- Start latency: `out_clk` rises at the posedge that accepts the ratio from OFF.
- Even N: high N/2 cycles, low N/2 cycles.
- Odd N: rises at posedge, falls at a negedge. Example for N=3: high 1.5 clk, low 1.5 clk.
- Ratio switch: the old ratio completes its current period. The first new-ratio period starts at the boundary edge. The worst-case wait is div_r-1 cycles, and `cfg_ready` is low for that time.
- Stop: `out_clk` stays low from the boundary edge onward. `busy` drops at the same edge.
- `period_tick` asserts during the cycle where `cnt == div_r-1`, in RUN and SWITCH.
- `cfg_err` is high for the single cycle following the accepting edge.

## Structure
- Package `clkdiv_pkg`:
  - state enum {OFF, RUN, SWITCH}.
  - `CNT_W_DEF = 8`.
  - command encodings `CMD_STOP = 0`, `CMD_ILLEGAL = 1`.
- Sub-module `clkdiv_core`:
  - Contents: counter, `p_q`/`n_q` flops, OR output.
  - Inputs: `div_r`, `odd_r`, `run`, `load`.
  - `clkdiv_sched` holds the FSM, `pend`, and the handshake.

## Test plan
- Reset, then N=4 → `out_clk` high 2 / low 2 clk; `period_tick` every 4th cycle; `cur_div = 4`.
- N=3 → `out_clk` high 1.5 / low 1.5 clk; falling edge aligned to a clk negedge; N=5 gives 2.5 / 2.5.
- In RUN with N=4 at `cnt=1`, send 6 → `cfg_ready` low for 2 cycles; N=6 period starts at the boundary; no short pulse.
- Send 3 exactly when `cnt = div_r-1` → applied the same edge; `cfg_ready` never drops.
- Send 1 in RUN → `cfg_err` one-cycle pulse; `cur_div` unchanged; clock undisturbed. Then send 0 → `out_clk` low at the boundary; `busy=0`; `cur_div=0`.
- Assert `rst=0` mid high-phase with N=7 → `out_clk` low within half a cycle; all outputs at reset values; restart with N=2 works.
